// File: rtl/pipe_ctl_fsm.sv
// pipe_ctl_fsm: mips789 pipeline stall/IRQ controller (clk, rst, pause, id_cmd, irq, irq_mask -> iack, irq_id, busy, zz_is_nop, id2ra/ra2exec strobes, pc_prectl)
module pipe_ctl_fsm #(
  parameter int MUL_CYCLES = 32,
  parameter int LD_CYCLES  = 1,
  parameter int CNT_W      = 6,
  parameter int NIRQ       = 4,
  parameter int IRQ_IDW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic [2:0]         id_cmd,
  input  logic [NIRQ-1:0]    irq,
  input  logic [NIRQ-1:0]    irq_mask,
  output logic               iack,
  output logic [IRQ_IDW-1:0] irq_id,
  output logic               busy,
  output logic               zz_is_nop,
  output logic               id2ra_ins_clr,
  output logic               id2ra_ins_cls,
  output logic               id2ra_ctl_clr,
  output logic               id2ra_ctl_cls,
  output logic               ra2exec_ctl_clr,
  output logic [3:0]         pc_prectl
);
  typedef enum logic [2:0] {S_RST, S_IDLE, S_NOI, S_CUR, S_MUL, S_LD, S_IRQ, S_RET} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IRQ_IDW-1:0] irq_sel;
  logic [NIRQ-1:0] req;
  logic pend, mul_done, ld_done;
  assign req = irq & irq_mask;
  assign pend = |req & ~iack;
  assign mul_done = cnt == CNT_W'(MUL_CYCLES - 1);
  assign ld_done = cnt == CNT_W'(LD_CYCLES - 1);
  always_comb begin
    irq_sel = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (req[i]) irq_sel = IRQ_IDW'(i);
  end
  always_comb begin
    nxt = state;
    cnt_nxt = '0;
    case (state)
      S_IDLE, S_NOI:
        nxt = pend          ? S_IRQ :
              id_cmd == 3'd0 ? S_NOI :
              id_cmd == 3'd1 ? S_CUR :
              id_cmd == 3'd2 ? S_MUL :
              id_cmd == 3'd3 ? S_LD  :
              id_cmd == 3'd4 ? S_RET : S_IDLE;
      S_CUR: nxt = S_NOI;
      S_MUL: begin
        nxt = mul_done ? S_IDLE : S_MUL;
        cnt_nxt = mul_done ? '0 : cnt + 1'b1;
      end
      S_LD: begin
        nxt = ld_done ? S_IDLE : S_LD;
        cnt_nxt = ld_done ? '0 : cnt + 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RST;
      cnt <= '0;
      iack <= 1'b0;
      irq_id <= '0;
    end else if (!pause) begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (nxt == S_IRQ) begin
        iack <= 1'b1;
        irq_id <= irq_sel;
      end else if (nxt == S_RET) iack <= 1'b0;
    end
  end
  assign busy = state inside {S_MUL, S_LD, S_IRQ, S_RST};
  assign zz_is_nop = state inside {S_CUR, S_RST};
  assign id2ra_ins_clr = state inside {S_MUL, S_LD, S_IRQ, S_RST};
  assign id2ra_ctl_clr = id2ra_ins_clr;
  assign id2ra_ins_cls = state == S_CUR;
  assign id2ra_ctl_cls = id2ra_ins_cls;
  assign ra2exec_ctl_clr = state inside {S_CUR, S_IRQ, S_RST};
  assign pc_prectl = state == S_RST ? 4'd3 :
                     state == S_IRQ ? 4'd2 :
                     state inside {S_CUR, S_MUL, S_LD} ? 4'd1 : 4'd0;
endmodule

// File: tb/tb_pipe_ctl_fsm.sv
// tb_pipe_ctl_fsm: scoreboard bench for pipe_ctl_fsm against a mode/countdown reference model
module tb_pipe_ctl_fsm;
  localparam int MULC = 32, LDC = 1;
  logic clk = 0, rst = 1, pause = 0;
  logic [2:0] id_cmd = 0;
  logic [3:0] irq = 0, irq_mask = 0;
  logic iack, busy, zz_is_nop, ins_clr, ins_cls, ctl_clr, ctl_cls, ra_clr;
  logic [1:0] irq_id;
  logic [3:0] pc_prectl;
  pipe_ctl_fsm #(.MUL_CYCLES(MULC), .LD_CYCLES(LDC), .CNT_W(6), .NIRQ(4), .IRQ_IDW(2)) dut (
    .clk(clk), .rst(rst), .pause(pause), .id_cmd(id_cmd), .irq(irq), .irq_mask(irq_mask),
    .iack(iack), .irq_id(irq_id), .busy(busy), .zz_is_nop(zz_is_nop),
    .id2ra_ins_clr(ins_clr), .id2ra_ins_cls(ins_cls), .id2ra_ctl_clr(ctl_clr),
    .id2ra_ctl_cls(ctl_cls), .ra2exec_ctl_clr(ra_clr), .pc_prectl(pc_prectl));
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  logic [13:0] sb[$];
  string m_mode = "RST";
  int m_left = 0, m_iack = 0, m_id = 0;
  logic p_rst = 1, p_pause = 0;
  logic [2:0] p_cmd = 0;
  logic [3:0] p_irq = 0, p_mask = 0;
  function automatic logic [13:0] expected();
    logic [4:0] s;
    logic [3:0] pc;
    logic nop, bsy;
    s = 0; pc = 0; nop = 0; bsy = 0;
    case (m_mode)
      "CUR": begin s = 5'b01011; pc = 1; nop = 1; end
      "MUL", "LD": begin s = 5'b10100; pc = 1; bsy = 1; end
      "IRQ": begin s = 5'b10101; pc = 2; bsy = 1; end
      "RST": begin s = 5'b10101; pc = 3; nop = 1; bsy = 1; end
      default: ;
    endcase
    return {1'(m_iack), 2'(m_id), bsy, nop, s, pc};
  endfunction
  task automatic model_edge();
    logic [3:0] r;
    if (p_rst) begin m_mode = "RST"; m_iack = 0; m_id = 0; return; end
    if (p_pause) return;
    r = p_irq & p_mask;
    if (m_mode == "IDLE" || m_mode == "NOI") begin
      if (r != 0 && m_iack == 0) begin
        m_mode = "IRQ"; m_iack = 1;
        for (int i = 3; i >= 0; i--) if (r[i]) m_id = i;
      end else case (p_cmd)
        0: m_mode = "NOI";
        1: m_mode = "CUR";
        2: begin m_mode = "MUL"; m_left = MULC; end
        3: begin m_mode = "LD"; m_left = LDC; end
        4: begin m_mode = "RET"; m_iack = 0; end
        default: m_mode = "IDLE";
      endcase
    end else if (m_mode == "MUL" || m_mode == "LD") begin
      m_left--;
      if (m_left == 0) m_mode = "IDLE";
    end else if (m_mode == "CUR") m_mode = "NOI";
    else m_mode = "IDLE";
  endtask
  task automatic drive(input logic r, input logic p, input logic [2:0] c, input logic [3:0] q, input logic [3:0] m);
    @(posedge clk);
    #1;
    model_edge();
    rst = r; pause = p; id_cmd = c; irq = q; irq_mask = m;
    p_rst = r; p_pause = p; p_cmd = c; p_irq = q; p_mask = m;
    if (r) begin m_mode = "RST"; m_iack = 0; m_id = 0; end
    sb.push_back(expected());
  endtask
  always @(negedge clk) begin
    logic [13:0] e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {iack, irq_id, busy, zz_is_nop, ins_clr, ins_cls, ctl_clr, ctl_cls, ra_clr, pc_prectl};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs t=%0t got %b want %b (iack,id,busy,nop,clr5,pc)", $time, a, e);
      end
    end
  end
  task automatic stall_len(input int pause_on, input int want, input string name);
    int n = 0;
    drive(0, 0, 2, 0, 0);
    for (int k = 0; k < 100; k++) begin
      drive(0, pause_on != 0 && k >= 10 && k < 15, 5, 0, 0);
      if (pc_prectl == 4'd1 && ins_clr) n++;
      else if (n > 0) break;
    end
    compared++;
    if (n != want) begin
      mismatched++;
      $display("FAIL %s got %0d cycles want %0d", name, n, want);
    end
  endtask
  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 5, 0, 0);
    stall_len(0, 32, "mul_len");
    stall_len(1, 37, "mul_len_paused");
    drive(0, 0, 5, 4'b1010, 4'b1111);
    repeat (3) drive(0, 0, 0, 4'b1010, 4'b1111);
    drive(0, 0, 4, 4'b1010, 4'b1111);
    drive(0, 0, 5, 0, 0);
    drive(0, 0, 5, 4'b0100, 4'b1011);
    drive(0, 0, 5, 4'b0100, 4'b1011);
    drive(0, 0, 5, 4'b0100, 4'b1111);
    drive(0, 0, 4, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 2, 0, 0);
    drive(0, 0, 2, 4'b0001, 4'b0001);
    drive(0, 0, 4, 0, 0);
    drive(0, 0, 2, 0, 0);
    repeat (5) drive(0, 0, 5, 0, 0);
    drive(1, 0, 5, 0, 0);
    drive(0, 0, 3, 0, 0);
    repeat (3) drive(0, 0, 5, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      drive($urandom_range(0, 249) == 0, $urandom_range(0, 7) == 0, c,
            ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0, 4'($urandom));
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
